// File: rtl/clk_div_switch.sv
// Divided clock generator with a run-time ratio switch that only changes ratio,
// stops or starts at a period boundary, so clkout never shows a runt phase.
module clk_div_switch #(
   parameter int DIV_W   = 8,
   parameter int RST_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             sw_req,
   output logic             sw_busy,
   output logic             sw_done,
   output logic [DIV_W-1:0] cur_ratio,
   output logic             clkout,
   output logic             clk_en
);

   // state  | meaning
   // S_STOP | ratio 0: clkout low, counter frozen; a pending ratio applies on any edge
   // S_RUN  | counting, no ratio change pending
   // S_PEND | counting, pending ratio applies when cnt reaches N-1
   typedef enum logic [1:0] {S_STOP, S_RUN, S_PEND} state_t;

   localparam logic [DIV_W-1:0] RST_RAW = DIV_W'(RST_DIV);
   localparam logic [DIV_W-1:0] RST_N   = (RST_RAW == DIV_W'(1)) ? DIV_W'(2) : RST_RAW;

   function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
      return (r == DIV_W'(1)) ? DIV_W'(2) : r;
   endfunction

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] cur_q, cur_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             clkout_q, clkout_d;
   logic             clk_en_q, clk_en_d;

   logic             last_cnt;
   logic             at_bound;
   logic             accept;
   logic             apply;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_d    = cur_q;
      pend_d   = pend_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      last_cnt = (cnt_q == cur_q - DIV_W'(1));
      at_bound = (state_q == S_STOP) || last_cnt;
      accept   = sw_req && !busy_q;
      apply    = busy_q && at_bound;

      if (apply) begin
         cur_d   = pend_q;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         cnt_d   = '0;
         state_d = (pend_q == '0) ? S_STOP : S_RUN;
      end else begin
         unique case (state_q)
            S_STOP: begin
               if (accept) begin
                  pend_d = clamp_ratio(div_ratio);
                  busy_d = 1'b1;
               end
            end
            S_RUN: begin
               cnt_d = last_cnt ? '0 : cnt_q + DIV_W'(1);
               if (accept) begin
                  pend_d  = clamp_ratio(div_ratio);
                  busy_d  = 1'b1;
                  state_d = S_PEND;
               end
            end
            S_PEND: begin
               cnt_d = cnt_q + DIV_W'(1);
            end
            default: state_d = S_STOP;
         endcase
      end

      // Outputs are registered from the next-cycle count so they line up with cnt_q.
      clkout_d = (state_d != S_STOP) && (cnt_d < (cur_d >> 1));
      clk_en_d = (state_d != S_STOP) && (cnt_d == cur_d - DIV_W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= (RST_N != '0) ? S_RUN : S_STOP;
         cnt_q    <= (RST_N != '0) ? RST_N - DIV_W'(1) : '0;
         cur_q    <= RST_N;
         pend_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         clkout_q <= 1'b0;
         clk_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_q    <= cur_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         clkout_q <= clkout_d;
         clk_en_q <= clk_en_d;
      end
   end

   assign sw_busy   = busy_q;
   assign sw_done   = done_q;
   assign cur_ratio = cur_q;
   assign clkout    = clkout_q;
   assign clk_en    = clk_en_q;

endmodule

// File: tb/tb_clk_div_switch.sv
// Bench for clk_div_switch: period-level reference model checked every cycle,
// plus literal waveform snapshots for each scenario of interest.
module tb_clk_div_switch;

   localparam int DIV_W   = 8;
   localparam int RST_DIV = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sw_req = 1'b0;
   logic [DIV_W-1:0] div_ratio = '0;
   logic             sw_busy, sw_done, clkout, clk_en;
   logic [DIV_W-1:0] cur_ratio;

   int n_checks = 0;
   int n_errors = 0;

   clk_div_switch #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .div_ratio (div_ratio),
      .sw_req    (sw_req),
      .sw_busy   (sw_busy),
      .sw_done   (sw_done),
      .cur_ratio (cur_ratio),
      .clkout    (clkout),
      .clk_en    (clk_en)
   );

   always #5 clk = ~clk;

   function automatic int clamp(input int r);
      return (r == 1) ? 2 : r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: ratio m_n (0 = stopped), position m_pos inside the current period.
   int m_n, m_pos, m_pend;
   bit m_busy, m_done, m_rst, m_valid;
   bit take_r, bound_r;

   always @(posedge clk) begin
      if (rst) begin
         m_n     = clamp(RST_DIV);
         m_pos   = (m_n > 0) ? m_n - 1 : 0;
         m_busy  = 0;
         m_done  = 0;
         m_rst   = 1;
         m_valid = 1;
      end else if (m_valid) begin
         bound_r = (m_n == 0) || (m_pos == m_n - 1);
         take_r  = sw_req && !m_busy;
         m_rst   = 0;
         m_done  = 0;
         if (m_busy && bound_r) begin
            m_n    = m_pend;
            m_pos  = 0;
            m_busy = 0;
            m_done = 1;
         end else if (m_n != 0) begin
            m_pos = (m_pos + 1) % m_n;
         end
         if (take_r) begin
            m_pend = clamp(int'(div_ratio));
            m_busy = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("clkout", 32'(clkout), 32'(!m_rst && m_n != 0 && m_pos < m_n / 2));
         check("clk_en", 32'(clk_en), 32'(!m_rst && m_n != 0 && m_pos == m_n - 1));
         check("sw_busy", 32'(sw_busy), 32'(m_busy));
         check("sw_done", 32'(sw_done), 32'(m_done));
         check("cur_ratio", 32'(cur_ratio), 32'(m_n));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int r);
      div_ratio = DIV_W'(r);
      sw_req    = 1'b1;
      tick();
      sw_req    = 1'b0;
   endtask

   task automatic capture(input int n, output logic [31:0] cl, output logic [31:0] ce,
                          output logic [31:0] bz, output logic [31:0] dn);
      cl = '0; ce = '0; bz = '0; dn = '0;
      repeat (n) begin
         @(negedge clk);
         cl = {cl[30:0], clkout};
         ce = {ce[30:0], clk_en};
         bz = {bz[30:0], sw_busy};
         dn = {dn[30:0], sw_done};
         tick();
      end
   endtask

   logic [31:0] cl, ce, bz, dn;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_clkout", 32'(clkout), 32'd0);
      check("rst_clk_en", 32'(clk_en), 32'd0);
      check("rst_busy", 32'(sw_busy), 32'd0);
      check("rst_cur", 32'(cur_ratio), 32'd4);
      tick();

      capture(8, cl, ce, bz, dn);
      check("r4_clkout", cl, 32'b11001100);
      check("r4_clk_en", ce, 32'b00010001);

      // stop request sampled on the edge leaving cnt=0 of ratio 4
      req(0);
      capture(10, cl, ce, bz, dn);
      check("stop_clkout", cl, 32'b1000000000);
      check("stop_clk_en", ce, 32'b0010000000);
      check("stop_busy", bz, 32'b1110000000);
      check("stop_done", dn, 32'b0001000000);
      check("stop_cur", 32'(cur_ratio), 32'd0);

      req(2);
      capture(6, cl, ce, bz, dn);
      check("start_clkout", cl, 32'b010101);
      check("start_clk_en", ce, 32'b001010);
      check("start_busy", bz, 32'b100000);
      check("start_done", dn, 32'b010000);
      check("start_cur", 32'(cur_ratio), 32'd2);

      // 6 pending, 3 ignored while busy
      req(6);
      req(3);
      capture(8, cl, ce, bz, dn);
      check("busy_clkout", cl, 32'b01110001);
      check("busy_busy", bz, 32'b10000000);
      check("busy_done", dn, 32'b01000000);
      check("busy_cur", 32'(cur_ratio), 32'd6);

      req(1);
      repeat (4) tick();
      capture(4, cl, ce, bz, dn);
      check("clamp_clkout", cl, 32'b1010);
      check("clamp_done", dn, 32'b1000);
      check("clamp_cur", 32'(cur_ratio), 32'd2);

      req(4);
      tick();
      req(5);
      capture(13, cl, ce, bz, dn);
      check("r5_clkout", cl, 32'b1001100011000);
      check("r5_busy", bz, 32'b1110000000000);
      check("r5_done", dn, 32'b0001000000000);
      check("r5_cur", 32'(cur_ratio), 32'd5);

      req(4);
      repeat (4) tick();
      repeat (3) tick();
      // request sampled on the boundary edge itself
      req(8);
      capture(12, cl, ce, bz, dn);
      check("bnd_clkout", cl, 32'b110011110000);
      check("bnd_busy", bz, 32'b111100000000);
      check("bnd_done", dn, 32'b000010000000);
      check("bnd_cur", 32'(cur_ratio), 32'd8);

      req(5);
      repeat (7) tick();
      req(7);
      @(negedge clk);
      check("mid_busy", 32'(sw_busy), 32'd1);
      check("mid_clkout", 32'(clkout), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_clkout", 32'(clkout), 32'd0);
      check("mrst_busy", 32'(sw_busy), 32'd0);
      check("mrst_cur", 32'(cur_ratio), 32'd4);
      check("mrst_done", 32'(sw_done), 32'd0);
      tick();
      capture(8, cl, ce, bz, dn);
      check("mrst_pattern", cl, 32'b11001100);
      check("mrst_busy_seq", bz, 32'b00000000);

      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_div_switch.md
Name: clk_div_switch

Overview:
- Parametrised successor to the two-input glitch-free clock switch.
- Derives a divided output clock and a matching clock-enable from a single source clock.
- The divide ratio is selected at run time through a request/busy/done handshake.
- Ratio changes, and stop/start, take effect only at a period boundary, so clkout never has a runt pulse or a truncated phase.

Parameters:
DIV_W, 8, width of the ratio input and the internal period counter.
RST_DIV, 4, ratio active out of reset (0 = stopped out of reset; 1 is clamped to 2 as below).

Ports:
clk  input  1  source clock; all logic on its rising edge.
rst  input  1  synchronous reset, active-high.
div_ratio  input  DIV_W  requested divide ratio; sampled only when a request is accepted.
sw_req  input  1  switch request; accepted on an edge where sw_req=1 and sw_busy=0.
sw_busy  output  1  a ratio change is accepted but not yet applied.
sw_done  output  1  one-cycle pulse: the new ratio became active.
cur_ratio  output  DIV_W  ratio currently in effect (after clamping).
clkout  output  1  registered divided clock, glitch-free.
clk_en  output  1  one-cycle pulse in the cycle before each clkout rising edge.

Behaviour:
- Ratio rules:
  - Effective N = div_ratio, except 1 is clamped to 2. cur_ratio reports the clamped value.
  - N = 0 means stopped.
  - H = N>>1 high cycles and N-H low cycles. Odd N gives the longer low phase.
- Counter:
  - cnt runs 0..N-1 and wraps.
  - clkout = 1 in cycles where cnt < H, else 0. It is driven from a register; no combinational path from clk.
  - clk_en = 1 in the cycle where cnt = N-1 and N != 0.
- Reset (rst=1 on an edge):
  - clkout=0, clk_en=0, sw_busy=0, sw_done=0, cur_ratio=clamp(RST_DIV).
  - cnt is positioned at the last low cycle, pending request is cleared.
  - If RST_DIV != 0, the first edge with rst=0 starts a period: cnt=0, clkout=1.
  - If RST_DIV = 0, the block comes up stopped.
- States:
  - STOP: N=0. clkout=0, clk_en=0, cnt frozen.
  - RUN: counting, no pending change.
  - PEND: counting, pending ratio held.
  - STOP with pending counts as "at boundary" every cycle.
- Request acceptance (edge with sw_req=1 and sw_busy=0):
  - Latch clamp(div_ratio) as pending and set sw_busy=1 from the next cycle.
  - RUN→PEND; STOP→STOP with pending.
- Requests while busy: sw_req with sw_busy=1 is ignored. The pending value is not overwritten and no error is flagged.
- Apply:
  - On the first edge where sw_busy=1 and the block is at a boundary (cnt=N-1 in RUN/PEND, or any edge in STOP): cur_ratio←pending, sw_busy←0, sw_done←1 for exactly one cycle.
  - If the new N != 0: cnt←0, clkout←1 (the new period starts on this edge).
  - If the new N = 0: clkout stays 0 and the state goes to STOP.
- Boundary timing:
  - A request accepted on the boundary edge itself is not applied on that edge; it is applied at the next boundary.
  - Minimum busy time is one cycle.
- Same-ratio request: full handshake (busy, done). The clkout waveform is unchanged.
- Mid-period reset: synchronous, takes effect on that edge. Any current high phase is truncated (reset is the only permitted truncation). Pending request is dropped.
- Glitch-free guarantee: no period ever has a high or low phase shorter than that of its governing ratio, except under reset.
- Sizing target: 120–400 lines of RTL.

Test Plan:
- Reset release, RST_DIV=4:
  - clkout per cycle = 1,1,0,0 repeating.
  - clk_en=1 only on each 4th cycle (cnt=3).
  - cur_ratio=4, sw_busy=0.
- Change 4→5, sw_req pulsed at cnt=1:
  - sw_busy=1 for 3 cycles.
  - Current period completes as 1,1,0,0, then 1,1,0,0,0 repeating.
  - sw_done=1 in the first high cycle of the new period; cur_ratio=5.
- Stop, then restart:
  - Request ratio 0 at cnt=0 of a ratio-4 period: 1,1,0,0 completes, then clkout=0 and clk_en=0 indefinitely.
  - Then request 2: busy 1 cycle, clkout 1,0 repeating, cur_ratio=2.
- Busy and clamping:
  - While a request for 6 is pending, pulse sw_req with 3: ignored; the block switches to 6.
  - A later request of 1 yields cur_ratio=2 and pattern 1,0.
- Boundary request: request ratio 8 in the cycle where cnt=N-1 of ratio 4:
  - Not applied on that edge; one more 1,1,0,0 period runs.
  - Then 1×4, 0×4 repeating.
- Reset mid-operation: assert rst while busy at cnt=1 of ratio 5:
  - Next cycle: clkout=0, sw_busy=0, cur_ratio=4.
  - Resumes the RST_DIV pattern.
